// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if -- instruction/data request ports and SRAM command bus of the arbiter.
// rev 1.0
`default_nettype none

interface sram_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Requesters plus the SRAM model: drive requests and read data, observe everything else.
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_arbiter.sv
// sram_arbiter -- round-robin arbitration of inst/data ports onto one synchronous SRAM.
// rev 1.0
`default_nettype none

module sram_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESP_I = 2'd1;
    localparam logic [1:0] RESP_D = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_d;
    logic       grant_i;
    logic       grant_d;
    logic       conflict;

    // last_d=1 means data won the previous conflict, so inst wins the next one.
    always_comb begin
        conflict = ~rst & bus.inst_req & bus.data_req;
        grant_d  = ~rst & bus.data_req & (~bus.inst_req | ~last_d);
        grant_i  = ~rst & bus.inst_req & ~grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= ~DATA_FIRST;
        end else begin
            state <= state_nxt;
            if (conflict) begin
                last_d <= grant_d;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (grant_i) begin
            state_nxt = RESP_I;
        end else if (grant_d) begin
            state_nxt = RESP_D;
        end
    end

    always_comb begin
        bus.inst_addr_ok = grant_i;
        bus.data_addr_ok = grant_d;
        bus.mem_en       = grant_i | grant_d;
        bus.mem_wen      = 4'b0;
        bus.mem_addr     = 32'h0;
        bus.mem_wdata    = 32'h0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;

        if (grant_i) begin
            bus.mem_addr = bus.inst_addr;
        end else if (grant_d) begin
            bus.mem_addr  = bus.data_addr;
            bus.mem_wen   = bus.data_wr ? bus.data_wstrb : 4'b0;
            bus.mem_wdata = bus.data_wdata;
        end

        // The response slot is masked while rst is high, even before state clears.
        if (!rst) begin
            case (state)
                RESP_I: begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = bus.mem_rdata;
                end
                RESP_D: begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- scoreboard bench: predicted grants queue expected responses one cycle ahead.
// rev 1.0
`default_nettype none

module tb_sram_arbiter;

    localparam bit DATA_FIRST = 1'b1;

    typedef struct {
        logic        is_d;
        logic        is_wr;
        logic [31:0] rdata;
    } resp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    resp_t sb[$];
    resp_t it;
    logic  m_last_d;
    logic  gi;
    logic  gd;

    sram_arbiter_if bus ();

    sram_arbiter #(.DATA_FIRST(DATA_FIRST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous SRAM stand-in: data one cycle after the command.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? mem_fn(bus.mem_addr) : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_inst_addr_ok", 32'(bus.inst_addr_ok), 32'h0);
            check("rst_data_addr_ok", 32'(bus.data_addr_ok), 32'h0);
            check("rst_inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
            check("rst_data_data_ok", 32'(bus.data_data_ok), 32'h0);
            check("rst_mem_en", 32'(bus.mem_en), 32'h0);
            check("rst_mem_wen", 32'(bus.mem_wen), 32'h0);
            check("rst_inst_rdata", bus.inst_rdata, 32'h0);
            check("rst_data_rdata", bus.data_rdata, 32'h0);
            sb.delete();
            m_last_d = ~DATA_FIRST;
        end else begin
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check("inst_data_ok", 32'(bus.inst_data_ok), 32'(!it.is_d));
                check("data_data_ok", 32'(bus.data_data_ok), 32'(it.is_d));
                if (!it.is_d) begin
                    check("inst_rdata", bus.inst_rdata, it.rdata);
                    check("data_rdata_idle", bus.data_rdata, 32'h0);
                end else begin
                    check("inst_rdata_idle", bus.inst_rdata, 32'h0);
                    if (!it.is_wr) check("data_rdata", bus.data_rdata, it.rdata);
                end
            end else begin
                check("no_inst_data_ok", 32'(bus.inst_data_ok), 32'h0);
                check("no_data_data_ok", 32'(bus.data_data_ok), 32'h0);
                check("no_inst_rdata", bus.inst_rdata, 32'h0);
                check("no_data_rdata", bus.data_rdata, 32'h0);
            end

            gd = bus.data_req && (!bus.inst_req || !m_last_d);
            gi = bus.inst_req && !gd;
            check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(gi));
            check("data_addr_ok", 32'(bus.data_addr_ok), 32'(gd));
            check("mem_en", 32'(bus.mem_en), 32'(gi || gd));
            if (gi) begin
                check("mem_addr_i", bus.mem_addr, bus.inst_addr);
                check("mem_wen_i", 32'(bus.mem_wen), 32'h0);
                sb.push_back('{is_d: 1'b0, is_wr: 1'b0, rdata: mem_fn(bus.inst_addr)});
            end else if (gd) begin
                check("mem_addr_d", bus.mem_addr, bus.data_addr);
                check("mem_wen_d", 32'(bus.mem_wen), bus.data_wr ? 32'(bus.data_wstrb) : 32'h0);
                check("mem_wdata_d", bus.mem_wdata, bus.data_wdata);
                sb.push_back('{is_d: 1'b1, is_wr: bus.data_wr, rdata: mem_fn(bus.data_addr)});
            end else begin
                check("idle_mem_addr", bus.mem_addr, 32'h0);
                check("idle_mem_wen", 32'(bus.mem_wen), 32'h0);
                check("idle_mem_wdata", bus.mem_wdata, 32'h0);
            end
            if (bus.inst_req && bus.data_req) m_last_d = gd;
        end
    end

    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [3:0] ds,
                       input logic [31:0] da, input logic [31:0] dd);
        bus.inst_req   = ir;
        bus.inst_addr  = ia;
        bus.data_req   = dr;
        bus.data_wr    = dw;
        bus.data_wstrb = ds;
        bus.data_addr  = da;
        bus.data_wdata = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        m_last_d = ~DATA_FIRST;
        rst      = 1'b1;
        bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
        bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = 4'h0;
        bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        idle(10);
        cyc(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(1);

        // First conflict after reset: data must win, then alternate.
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 32'h1000 + 32'(k * 4), 1'b1, 1'b0, 4'h0, 32'h2000 + 32'(k * 4), 32'h0);
        idle(1);

        cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'h2, 32'h100, 32'h0000_AB00);
        idle(1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        idle(2);

        for (int k = 0; k < 40; k++)
            cyc(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                $urandom & 32'hFFFF_FFFC, $urandom);
        idle(1);

        // Reset right after an accepted inst read drops its response.
        cyc(1'b1, 32'h3000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        cyc(1'b1, 32'h4000, 1'b1, 1'b0, 4'h0, 32'h5000, 32'h0);
        cyc(1'b1, 32'h4004, 1'b1, 1'b0, 4'h0, 32'h5004, 32'h0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
